core_v_xif_copro_alu: RTL and testbench



---
 rtl/core_v_xif_copro_alu_if.sv | 60 ++++++
 rtl/core_v_xif_copro_alu.sv | 174 +++++++++++++++++
 tb/tb_core_v_xif_copro_alu.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_v_xif_copro_alu_if.sv
// Issue/register/commit/result channels between a host core (master) and the
// ALU coprocessor (slave). Compressed and memory channels are not carried.
interface core_v_xif_copro_alu_if #(
    parameter int X_ID_WIDTH     = 4,
    parameter int X_HARTID_WIDTH = 1
);
    logic                      issue_valid;
    logic                      issue_ready;
    logic [31:0]               issue_instr;
    logic [X_HARTID_WIDTH-1:0] issue_hartid;
    logic [X_ID_WIDTH-1:0]     issue_id;
    logic                      issue_accept;
    logic                      issue_writeback;
    logic [1:0]                issue_register_read;

    logic                      register_valid;
    logic                      register_ready;
    logic [X_ID_WIDTH-1:0]     register_id;
    logic [1:0][31:0]          register_rs;
    logic [1:0]                register_rs_valid;

    logic                      commit_valid;
    logic [X_ID_WIDTH-1:0]     commit_id;
    logic                      commit_kill;

    logic                      result_valid;
    logic                      result_ready;
    logic [X_ID_WIDTH-1:0]     result_id;
    logic [X_HARTID_WIDTH-1:0] result_hartid;
    logic [31:0]               result_data;
    logic [4:0]                result_rd;
    logic                      result_we;
    logic                      result_exc;
    logic [5:0]                result_exccode;
    logic                      result_dbg;
    logic                      result_err;
    logic [2:0]                result_ecswe;

    modport master (
        output issue_valid, issue_instr, issue_hartid, issue_id,
        input  issue_ready, issue_accept, issue_writeback, issue_register_read,
        output register_valid, register_id, register_rs, register_rs_valid,
        input  register_ready,
        output commit_valid, commit_id, commit_kill,
        input  result_valid, result_id, result_hartid, result_data, result_rd,
        input  result_we, result_exc, result_exccode, result_dbg, result_err, result_ecswe,
        output result_ready
    );

    modport slave (
        input  issue_valid, issue_instr, issue_hartid, issue_id,
        output issue_ready, issue_accept, issue_writeback, issue_register_read,
        input  register_valid, register_id, register_rs, register_rs_valid,
        output register_ready,
        input  commit_valid, commit_id, commit_kill,
        output result_valid, result_id, result_hartid, result_data, result_rd,
        output result_we, result_exc, result_exccode, result_dbg, result_err, result_ecswe,
        input  result_ready
    );
endinterface

// File: rtl/core_v_xif_copro_alu.sv
// CORE-V-XIF coprocessor endpoint: in-order queue of custom-0 ALU instructions
// that collects operands, waits for commit/kill and returns one writeback each.
module core_v_xif_copro_alu #(
    parameter int X_ID_WIDTH     = 4,
    parameter int X_HARTID_WIDTH = 1,
    parameter int DEPTH          = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    core_v_xif_copro_alu_if.slave  xif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef logic [PW-1:0] ptr_t;

    logic [X_ID_WIDTH-1:0]     id_mem     [DEPTH];
    logic [X_HARTID_WIDTH-1:0] hartid_mem [DEPTH];
    logic [2:0]                funct3_mem [DEPTH];
    logic [4:0]                rd_mem     [DEPTH];
    logic [31:0]               rs1_mem    [DEPTH];
    logic [31:0]               rs2_mem    [DEPTH];
    logic                      ops_ok_reg    [DEPTH];
    logic                      committed_reg [DEPTH];
    logic                      killed_reg    [DEPTH];

    ptr_t          head_reg, tail_reg;
    logic [CW-1:0] count_reg;
    logic          register_ready_reg;

    logic                      result_valid_reg;
    logic [X_ID_WIDTH-1:0]     result_id_reg;
    logic [X_HARTID_WIDTH-1:0] result_hartid_reg;
    logic [31:0]               result_data_reg;
    logic [4:0]                result_rd_reg;

    logic instr_ok, push, pop, load, head_kill_pop, head_live, slot_free;
    logic reg_hit, cmt_hit;
    ptr_t reg_idx, cmt_idx;
    logic unused_instr_bits;

    function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        case (f3)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a ^ b;
            3'b011:  return (a < b) ? a : b;
            3'b100:  return (a < b) ? b : a;
            3'b101:  return a << b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    assign instr_ok = (xif.issue_instr[6:0] == 7'b0001011) &&
                      (xif.issue_instr[31:25] == 7'b0) &&
                      (xif.issue_instr[14:12] <= 3'b101);
    assign unused_instr_bits = ^xif.issue_instr[24:15];

    // Response bits are only meaningful while an issue request is presented.
    assign xif.issue_ready         = (count_reg < CW'(DEPTH));
    assign xif.issue_accept        = xif.issue_valid & instr_ok;
    assign xif.issue_writeback     = xif.issue_valid & instr_ok;
    assign xif.issue_register_read = {2{xif.issue_valid & instr_ok}};
    assign xif.register_ready      = register_ready_reg;

    assign push = xif.issue_valid & xif.issue_ready & instr_ok;

    // Oldest live entry wins when ids alias; done entries are skipped so a reused id finds the new one.
    always_comb begin
        reg_hit = 1'b0;
        reg_idx = '0;
        cmt_hit = 1'b0;
        cmt_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ptr_t idx;
            idx = head_reg + PW'(k);
            if (CW'(k) < count_reg) begin
                if (!reg_hit && xif.register_valid && !ops_ok_reg[idx] &&
                    id_mem[idx] == xif.register_id) begin
                    reg_hit = 1'b1;
                    reg_idx = idx;
                end
                if (!cmt_hit && xif.commit_valid && !committed_reg[idx] && !killed_reg[idx] &&
                    id_mem[idx] == xif.commit_id) begin
                    cmt_hit = 1'b1;
                    cmt_idx = idx;
                end
            end
        end
    end

    assign head_live     = (count_reg != '0);
    assign head_kill_pop = head_live & killed_reg[head_reg];
    assign slot_free     = !result_valid_reg | xif.result_ready;
    assign load          = head_live & ops_ok_reg[head_reg] & committed_reg[head_reg] &
                           !killed_reg[head_reg] & slot_free;
    assign pop           = head_kill_pop | load;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_reg           <= '0;
            tail_reg           <= '0;
            count_reg          <= '0;
            register_ready_reg <= 1'b0;
        end else begin
            register_ready_reg <= 1'b1;
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                ops_ok_reg[gi]    <= 1'b0;
                committed_reg[gi] <= 1'b0;
                killed_reg[gi]    <= 1'b0;
            end else if (push && tail_reg == PW'(gi)) begin
                id_mem[gi]        <= xif.issue_id;
                hartid_mem[gi]    <= xif.issue_hartid;
                funct3_mem[gi]    <= xif.issue_instr[14:12];
                rd_mem[gi]        <= xif.issue_instr[11:7];
                ops_ok_reg[gi]    <= 1'b0;
                committed_reg[gi] <= 1'b0;
                killed_reg[gi]    <= 1'b0;
            end else begin
                if (reg_hit && reg_idx == PW'(gi) && xif.register_rs_valid == 2'b11) begin
                    rs1_mem[gi]    <= xif.register_rs[0];
                    rs2_mem[gi]    <= xif.register_rs[1];
                    ops_ok_reg[gi] <= 1'b1;
                end
                if (cmt_hit && cmt_idx == PW'(gi)) begin
                    if (xif.commit_kill) killed_reg[gi]    <= 1'b1;
                    else                 committed_reg[gi] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_valid_reg  <= 1'b0;
            result_id_reg     <= '0;
            result_hartid_reg <= '0;
            result_data_reg   <= '0;
            result_rd_reg     <= '0;
        end else if (load) begin
            result_valid_reg  <= 1'b1;
            result_id_reg     <= id_mem[head_reg];
            result_hartid_reg <= hartid_mem[head_reg];
            result_data_reg   <= alu_op(funct3_mem[head_reg], rs1_mem[head_reg], rs2_mem[head_reg]);
            result_rd_reg     <= rd_mem[head_reg];
        end else if (xif.result_ready) begin
            result_valid_reg  <= 1'b0;
        end
    end

    assign xif.result_valid   = result_valid_reg;
    assign xif.result_id      = result_id_reg;
    assign xif.result_hartid  = result_hartid_reg;
    assign xif.result_data    = result_data_reg;
    assign xif.result_rd      = result_rd_reg;
    assign xif.result_we      = result_valid_reg;
    assign xif.result_exc     = 1'b0;
    assign xif.result_exccode = '0;
    assign xif.result_dbg     = 1'b0;
    assign xif.result_err     = 1'b0;
    assign xif.result_ecswe   = '0;
endmodule

// File: tb/tb_core_v_xif_copro_alu.sv
// Scoreboard bench for core_v_xif_copro_alu: expected writebacks are queued at
// issue time and compared by a monitor as each result handshake happens.
module tb_core_v_xif_copro_alu;
    localparam int IW = 4;
    localparam int HW = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_v_xif_copro_alu_if #(.X_ID_WIDTH(IW), .X_HARTID_WIDTH(HW)) xif ();

    core_v_xif_copro_alu #(.X_ID_WIDTH(IW), .X_HARTID_WIDTH(HW), .DEPTH(4)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .xif   (xif)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [HW-1:0] hartid;
        logic [4:0]    rd;
        logic [31:0]   data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        if (f3 == 3'd0) r = a + b;
        if (f3 == 3'd1) r = a + ~b + 32'd1;
        if (f3 == 3'd2) r = (a | b) & ~(a & b);
        if (f3 == 3'd3) r = ($unsigned(a) <= $unsigned(b)) ? a : b;
        if (f3 == 3'd4) r = ($unsigned(a) >= $unsigned(b)) ? a : b;
        if (f3 == 3'd5) r = a << (b % 32);
        return r;
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0, 5'd2, 5'd1, f3, rd, 7'b0001011};
    endfunction

    // Result monitor: every handshake pops one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && xif.result_valid && xif.result_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL result_unexpected: got id=%0d data=%h, required no result",
                         xif.result_id, xif.result_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (xif.result_id !== mon_e.id || xif.result_data !== mon_e.data ||
                    xif.result_rd !== mon_e.rd || xif.result_hartid !== mon_e.hartid ||
                    xif.result_we !== 1'b1)
                    $display("FAIL result: got id=%0d hart=%0d rd=%0d data=%h we=%b, required id=%0d hart=%0d rd=%0d data=%h we=1",
                             xif.result_id, xif.result_hartid, xif.result_rd, xif.result_data,
                             xif.result_we, mon_e.id, mon_e.hartid, mon_e.rd, mon_e.data);
                else begin
                    n_pass++;
                    $display("result id=%0d rd=%0d data=%h ok", xif.result_id, xif.result_rd,
                             xif.result_data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [IW-1:0] id, input logic [HW-1:0] hart,
                            input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.id = id; e.hartid = hart; e.rd = rd; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_issue(input logic [IW-1:0] id, input logic [HW-1:0] hart,
                            input logic [31:0] instr, output logic acc, output logic wb,
                            output logic [1:0] rr);
        int w = 0;
        xif.issue_valid = 1'b1; xif.issue_id = id; xif.issue_hartid = hart;
        xif.issue_instr = instr;
        @(negedge clk);
        while (!xif.issue_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        acc = xif.issue_accept; wb = xif.issue_writeback; rr = xif.issue_register_read;
        if (!xif.issue_ready) begin
            n_checks++;
            $display("FAIL issue_timeout: issue_ready=0 after 50 cycles, required 1");
        end
        @(posedge clk);
        #1;
        xif.issue_valid = 1'b0;
        $display("issue id=%0d instr=%h accept=%b", id, instr, acc);
    endtask

    task automatic do_reg(input logic [IW-1:0] id, input logic [31:0] rs1, input logic [31:0] rs2);
        xif.register_valid = 1'b1; xif.register_id = id;
        xif.register_rs = {rs2, rs1}; xif.register_rs_valid = 2'b11;
        tick();
        xif.register_valid = 1'b0;
        $display("register id=%0d rs1=%h rs2=%h", id, rs1, rs2);
    endtask

    task automatic do_commit(input logic [IW-1:0] id, input logic kill);
        xif.commit_valid = 1'b1; xif.commit_id = id; xif.commit_kill = kill;
        tick();
        xif.commit_valid = 1'b0;
        $display("commit id=%0d kill=%b", id, kill);
    endtask

    task automatic wait_drain(input int budget);
        int w = 0;
        while ((exp_q.size() != 0 || xif.result_valid) && w < budget) begin
            tick();
            w++;
        end
        n_checks++;
        if (exp_q.size() != 0 || xif.result_valid)
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (xif.result_valid !== 1'b0) $display("FAIL reset_result_valid: got %b want 0", xif.result_valid);
        else n_pass++;
        n_checks++;
        if (xif.register_ready !== 1'b0) $display("FAIL reset_register_ready: got %b want 0", xif.register_ready);
        else n_pass++;
        n_checks++;
        if (xif.result_data !== 32'h0 || xif.result_id !== '0 || xif.result_rd !== 5'd0)
            $display("FAIL reset_result_fields: got data=%h id=%0d rd=%0d want 0", xif.result_data, xif.result_id, xif.result_rd);
        else n_pass++;
        n_checks++;
        if (xif.issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b want 1", xif.issue_ready);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (xif.register_ready !== 1'b1) $display("FAIL register_ready_after_reset: got %b want 1", xif.register_ready);
        else n_pass++;
    endtask

    task automatic test_add();
        logic acc, wb;
        logic [1:0] rr;
        push_exp(4'd3, 1'b1, 5'd5, 32'd16);
        do_issue(4'd3, 1'b1, mk(3'b000, 5'd5), acc, wb, rr);
        n_checks++;
        if (acc !== 1'b1 || wb !== 1'b1 || rr !== 2'b11)
            $display("FAIL add_issue_resp: got acc=%b wb=%b rr=%b want 1 1 11", acc, wb, rr);
        else n_pass++;
        do_reg(4'd3, 32'd7, 32'd9);
        do_commit(4'd3, 1'b0);
        wait_drain(20);
    endtask

    task automatic test_reject();
        logic acc, wb;
        logic [1:0] rr;
        logic [31:0] bad;
        bad = {7'b0, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011};
        do_issue(4'd4, 1'b0, bad, acc, wb, rr);
        n_checks++;
        if (acc !== 1'b0 || wb !== 1'b0 || rr !== 2'b00)
            $display("FAIL reject_opcode: got acc=%b wb=%b rr=%b want 0 0 00", acc, wb, rr);
        else n_pass++;
        do_issue(4'd5, 1'b0, mk(3'b110, 5'd5), acc, wb, rr);
        n_checks++;
        if (acc !== 1'b0) $display("FAIL reject_funct3: got accept=%b want 0", acc);
        else n_pass++;
        bad = mk(3'b000, 5'd5) | 32'h4000_0000;
        do_issue(4'd6, 1'b0, bad, acc, wb, rr);
        n_checks++;
        if (acc !== 1'b0) $display("FAIL reject_funct7: got accept=%b want 0", acc);
        else n_pass++;
        xif.issue_instr = mk(3'b000, 5'd1);
        #1;
        n_checks++;
        if (xif.issue_accept !== 1'b0) $display("FAIL accept_without_valid: got %b want 0", xif.issue_accept);
        else n_pass++;
        do_reg(4'd4, 32'd1, 32'd2);
        do_commit(4'd4, 1'b0);
        repeat (10) tick();
        n_checks++;
        if (xif.result_valid !== 1'b0 || xif.issue_ready !== 1'b1)
            $display("FAIL reject_not_queued: got valid=%b ready=%b want 0 1", xif.result_valid, xif.issue_ready);
        else n_pass++;
    endtask

    task automatic test_full();
        logic acc, wb;
        logic [1:0] rr;
        int w;
        for (int i = 0; i < 4; i++) begin
            push_exp(IW'(i), 1'b0, 5'(10 + i), model(3'(i), 32'(100 + 7 * i), 32'(3 + 50 * i)));
            do_issue(IW'(i), 1'b0, mk(3'(i), 5'(10 + i)), acc, wb, rr);
        end
        @(negedge clk);
        n_checks++;
        if (xif.issue_ready !== 1'b0) $display("FAIL full_issue_ready: got %b want 0", xif.issue_ready);
        else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) do_reg(IW'(i), 32'(100 + 7 * i), 32'(3 + 50 * i));
        n_checks++;
        if (xif.issue_ready !== 1'b0 || xif.result_valid !== 1'b0)
            $display("FAIL full_no_commit: got ready=%b valid=%b want 0 0", xif.issue_ready, xif.result_valid);
        else n_pass++;
        do_commit(4'd0, 1'b0);
        w = 0;
        @(negedge clk);
        while (!xif.result_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (xif.result_valid !== 1'b1 || xif.issue_ready !== 1'b1)
            $display("FAIL full_pop_ready: got valid=%b ready=%b want 1 1", xif.result_valid, xif.issue_ready);
        else n_pass++;
        tick();
        for (int i = 1; i < 4; i++) do_commit(IW'(i), 1'b0);
        wait_drain(30);
    endtask

    task automatic test_kill();
        logic acc, wb;
        logic [1:0] rr;
        do_issue(4'd1, 1'b0, mk(3'b000, 5'd6), acc, wb, rr);
        push_exp(4'd2, 1'b1, 5'd7, model(3'b010, 32'hF0F0_1234, 32'h0FF0_0004));
        do_issue(4'd2, 1'b1, mk(3'b010, 5'd7), acc, wb, rr);
        do_reg(4'd1, 32'd5, 32'd6);
        do_commit(4'd1, 1'b1);
        do_commit(4'd2, 1'b0);
        repeat (3) tick();
        n_checks++;
        if (xif.result_valid !== 1'b0) $display("FAIL kill_early_result: got valid=%b want 0", xif.result_valid);
        else n_pass++;
        do_reg(4'd2, 32'hF0F0_1234, 32'h0FF0_0004);
        wait_drain(30);
    endtask

    task automatic test_backpressure();
        logic acc, wb;
        logic [1:0] rr;
        int w;
        xif.result_ready = 1'b0;
        push_exp(4'd6, 1'b0, 5'd9, 32'hFFFF_FFFE);
        do_issue(4'd6, 1'b0, mk(3'b001, 5'd9), acc, wb, rr);
        push_exp(4'd7, 1'b0, 5'd11, model(3'b100, 32'h8000_0000, 32'h7FFF_FFFF));
        do_issue(4'd7, 1'b0, mk(3'b100, 5'd11), acc, wb, rr);
        do_reg(4'd6, 32'd3, 32'd5);
        do_commit(4'd6, 1'b0);
        do_reg(4'd7, 32'h8000_0000, 32'h7FFF_FFFF);
        do_commit(4'd7, 1'b0);
        w = 0;
        @(negedge clk);
        while (!xif.result_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (xif.result_valid !== 1'b1 || xif.result_data !== 32'hFFFF_FFFE || xif.result_id !== 4'd6)
                $display("FAIL backpressure_hold cycle %0d: got valid=%b id=%0d data=%h want 1 6 fffffffe",
                         c, xif.result_valid, xif.result_id, xif.result_data);
            else n_pass++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        xif.result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (xif.result_valid !== 1'b1 || xif.result_id !== 4'd7)
            $display("FAIL back_to_back_load: got valid=%b id=%0d want 1 7", xif.result_valid, xif.result_id);
        else n_pass++;
        wait_drain(20);
    endtask

    task automatic test_back_to_back();
        logic acc, wb;
        logic [1:0] rr;
        logic [2:0]  f3 [4];
        logic [31:0] a  [4];
        logic [31:0] b  [4];
        f3[0] = 3'b101; a[0] = 32'h1234_5678; b[0] = 32'h0000_0023;
        f3[1] = 3'b100; a[1] = 32'h0000_0010; b[1] = 32'hFFFF_FFF0;
        f3[2] = 3'b011; a[2] = 32'h0000_0010; b[2] = 32'hFFFF_FFF0;
        f3[3] = 3'b000; a[3] = 32'hFFFF_FFFF; b[3] = 32'h0000_0002;
        for (int i = 0; i < 4; i++) begin
            push_exp(IW'(8 + i), 1'(i), 5'(12 + i), model(f3[i], a[i], b[i]));
            do_issue(IW'(8 + i), 1'(i), mk(f3[i], 5'(12 + i)), acc, wb, rr);
        end
        for (int i = 0; i < 4; i++) begin
            xif.register_valid = 1'b1; xif.register_id = IW'(8 + i);
            xif.register_rs = {b[i], a[i]}; xif.register_rs_valid = 2'b11;
            xif.commit_valid = 1'b1; xif.commit_id = IW'(8 + i); xif.commit_kill = 1'b0;
            tick();
            $display("register+commit id=%0d", 8 + i);
        end
        xif.register_valid = 1'b0;
        xif.commit_valid = 1'b0;
        wait_drain(30);
    endtask

    task automatic test_reset_mid();
        logic acc, wb;
        logic [1:0] rr;
        int w;
        xif.result_ready = 1'b0;
        do_issue(4'd1, 1'b0, mk(3'b000, 5'd3), acc, wb, rr);
        do_reg(4'd1, 32'd1, 32'd2);
        do_commit(4'd1, 1'b0);
        w = 0;
        while (!xif.result_valid && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (xif.result_valid !== 1'b1) $display("FAIL reset_mid_pending: got valid=%b want 1", xif.result_valid);
        else n_pass++;
        for (int i = 2; i < 5; i++) do_issue(IW'(i), 1'b0, mk(3'b000, 5'd3), acc, wb, rr);
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (xif.result_valid !== 1'b0 || xif.register_ready !== 1'b0)
            $display("FAIL reset_mid_clear: got valid=%b reg_ready=%b want 0 0", xif.result_valid, xif.register_ready);
        else n_pass++;
        xif.result_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (xif.issue_ready !== 1'b1 || xif.register_ready !== 1'b1)
            $display("FAIL reset_mid_release: got issue_ready=%b reg_ready=%b want 1 1", xif.issue_ready, xif.register_ready);
        else n_pass++;
        do_reg(4'd2, 32'd4, 32'd4);
        do_commit(4'd2, 1'b0);
        repeat (8) tick();
        n_checks++;
        if (xif.result_valid !== 1'b0) $display("FAIL reset_mid_stale: got valid=%b want 0", xif.result_valid);
        else n_pass++;
    endtask

    initial begin
        xif.issue_valid = 1'b0; xif.issue_instr = '0; xif.issue_hartid = '0; xif.issue_id = '0;
        xif.register_valid = 1'b0; xif.register_id = '0; xif.register_rs = '0;
        xif.register_rs_valid = 2'b00;
        xif.commit_valid = 1'b0; xif.commit_id = '0; xif.commit_kill = 1'b0;
        xif.result_ready = 1'b1;
        test_reset();
        test_add();
        test_reject();
        test_full();
        test_kill();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
